core_bus_arbiter: RTL
=====================

CORE_BUS_ARBITER -- requirements
Module: core_bus_arbiter

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, data width; ADDR_WIDTH, default 32, address width; TIMEOUT_CYCLES, default 255, maximum wait for a memory response.
REQ-002 SHALL have ports: clk in 1, the single clock; reset in 1, asynchronous active-high reset.
REQ-003 SHALL have data requester ports: d_req in 1; d_we in 1; d_addr in ADDR_WIDTH; d_wdata in DATA_WIDTH; d_rdata out DATA_WIDTH; d_ack out 1; d_err out 1.
REQ-004 SHALL have instruction requester ports: i_req in 1; i_addr in ADDR_WIDTH; i_rdata out DATA_WIDTH; i_ack out 1; i_err out 1.
REQ-005 SHALL have memory port signals: mem_read out 1; mem_write out 1; mem_address out ADDR_WIDTH; mem_write_data out DATA_WIDTH; mem_read_data in DATA_WIDTH; mem_response in 1.
REQ-006 SHALL have hold_o out 1, the stall request to the core.

Function
REQ-007 SHALL use FSM states IDLE, ACCESS, RESPOND; every output SHALL be registered.
REQ-008 In IDLE with any req high, the arbiter SHALL latch the winner's address, write data and write enable, then go to ACCESS.
REQ-009 In ACCESS, mem_read (instruction, or data with d_we=0) or mem_write (data with d_we=1) SHALL be held high together with stable address and data until mem_response=1.
REQ-010 On mem_response in ACCESS, the arbiter SHALL capture mem_read_data, drop the strobe on the next edge and go to RESPOND.
REQ-011 In RESPOND, the winner's ack SHALL pulse for exactly 1 cycle, its rdata SHALL hold the captured word until its next ack, and the FSM SHALL return to IDLE.
REQ-012 Minimum latency SHALL be: req sampled at edge N, strobe at N+1, response at N+1 gives ack at N+3.
REQ-013 Requesters SHALL hold req and request fields until ack; the arbiter SHALL ignore field changes after latching.
REQ-014 A req dropped before ack SHALL NOT abort the access, and the ack SHALL still be issued.
REQ-015 A wait counter SHALL count in ACCESS; when it reaches TIMEOUT_CYCLES with no response, the arbiter SHALL drop the strobe, set err=1 and rdata=0, pulse ack in RESPOND, and zero the counter.
REQ-016 mem_response outside ACCESS SHALL be ignored.
REQ-017 hold_o SHALL be 1 whenever d_req=1 and d_ack is not being asserted in that cycle.
REQ-018 err SHALL be valid only during ack and SHALL be 0 on normal completion.
REQ-019 A write SHALL return rdata equal to the mem_read_data captured at response.

Reset
REQ-020 reset SHALL asynchronously force IDLE, all strobes, acks, errs and hold_o to 0, rdata and mem fields to 0, the counter to 0, and the RR pointer to instruction-last.
REQ-021 Reset during ACCESS SHALL drop the strobe immediately, and no ack SHALL follow the deassertion of reset.

Configuration
REQ-022 With macro CORE_BUS_ARBITER_ROUND_ROBIN_EN defined, simultaneous requests in IDLE SHALL be granted to the requester not served last, and the pointer SHALL update at each ack.
REQ-023 Without CORE_BUS_ARBITER_ROUND_ROBIN_EN, simultaneous requests SHALL always be granted to data (fixed priority), and no pointer register SHALL exist.

Structure
REQ-024 Package core_bus_pkg SHALL hold the FSM state enum, the requester ID constants (REQ_DATA=0, REQ_INSTR=1) and the default width constants.
REQ-025 Winner selection (fixed or round-robin) SHALL be a sub-module bus_grant_select; the rest SHALL be inline.

Verification
REQ-026 Scenario: i_req alone, addr 0x100, response 1 cycle after strobe with data 0x00000013 -> mem_read with mem_address 0x100, i_ack 3 cycles after req, i_rdata 0x00000013.
REQ-027 Scenario: d_req with d_we=1, addr 0x2000, wdata 0xDEADBEEF -> mem_write with fields stable until response, d_ack 1 cycle, hold_o high until the ack cycle.
REQ-028 Scenario: d_req and i_req asserted together, 3 back-to-back rounds -> fixed build: D,D,D while both pending; RR build: D,I,D.
REQ-029 Scenario: no mem_response with TIMEOUT_CYCLES=8 -> strobe drops after 8 cycles, ack with err=1, rdata=0x0.
REQ-030 Scenario: reset pulse mid-ACCESS, then mem_response -> all outputs 0 asynchronously, no ack, and the next request is served normally.
REQ-031 Scenario: i_req dropped 1 cycle after grant -> access completes and i_ack pulses once.

Source files
------------

// File: rtl/core_bus_pkg.sv
// Shared types and constants for the core bus arbiter: FSM states, requester IDs
// and default widths.
package core_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  localparam logic REQ_DATA  = 1'b0;
  localparam logic REQ_INSTR = 1'b1;

  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_ADDR_WIDTH     = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/bus_grant_select.sv
// Picks the winning requester from d_req/i_req: data-first by default, alternating
// on contention when CORE_BUS_ARBITER_ROUND_ROBIN_EN is defined.
module bus_grant_select
  import core_bus_pkg::*;
(
  input  logic d_req_i,
  input  logic i_req_i,
`ifdef CORE_BUS_ARBITER_ROUND_ROBIN_EN
  input  logic last_id_i,
`endif
  output logic valid_o,
  output logic id_o
);

  assign valid_o = d_req_i | i_req_i;

`ifdef CORE_BUS_ARBITER_ROUND_ROBIN_EN
  always_comb begin
    id_o = d_req_i ? REQ_DATA : REQ_INSTR;
    // On contention the requester that was not served last wins.
    if (d_req_i && i_req_i) begin
      id_o = (last_id_i == REQ_DATA) ? REQ_INSTR : REQ_DATA;
    end
  end
`else
  assign id_o = d_req_i ? REQ_DATA : REQ_INSTR;
`endif

endmodule

// File: rtl/core_bus_arbiter.sv
// Two-requester (data/instruction) arbiter onto a single strobe/response memory port.
// Define CORE_BUS_ARBITER_ROUND_ROBIN_EN for round-robin grant on contention.
//
// state   | meaning
// IDLE    | waiting for a request; no grant in the cycle an ack is showing
// ACCESS  | strobe held with latched fields until response or timeout
// RESPOND | issue ack/err/rdata to the winner, then back to IDLE
module core_bus_arbiter
  import core_bus_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  d_err,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ack,
  output logic                  i_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  mem_response,
  output logic                  hold_o
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  win_q, win_d;
  logic                  tmo_q, tmo_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] cap_q, cap_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0] mem_write_data_q, mem_write_data_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic                  d_ack_q, d_ack_d;
  logic                  i_ack_q, i_ack_d;
  logic                  d_err_q, d_err_d;
  logic                  i_err_q, i_err_d;
  logic                  grant_valid;
  logic                  grant_id;
`ifdef CORE_BUS_ARBITER_ROUND_ROBIN_EN
  logic                  last_q, last_d;
`endif

  bus_grant_select u_grant (
    .d_req_i   (d_req),
    .i_req_i   (i_req),
`ifdef CORE_BUS_ARBITER_ROUND_ROBIN_EN
    .last_id_i (last_q),
`endif
    .valid_o   (grant_valid),
    .id_o      (grant_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      win_q            <= REQ_DATA;
      tmo_q            <= 1'b0;
      cnt_q            <= '0;
      cap_q            <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      d_rdata_q        <= '0;
      i_rdata_q        <= '0;
      d_ack_q          <= 1'b0;
      i_ack_q          <= 1'b0;
      d_err_q          <= 1'b0;
      i_err_q          <= 1'b0;
`ifdef CORE_BUS_ARBITER_ROUND_ROBIN_EN
      last_q           <= REQ_INSTR;
`endif
    end else begin
      state_q          <= state_d;
      win_q            <= win_d;
      tmo_q            <= tmo_d;
      cnt_q            <= cnt_d;
      cap_q            <= cap_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      d_rdata_q        <= d_rdata_d;
      i_rdata_q        <= i_rdata_d;
      d_ack_q          <= d_ack_d;
      i_ack_q          <= i_ack_d;
      d_err_q          <= d_err_d;
      i_err_q          <= i_err_d;
`ifdef CORE_BUS_ARBITER_ROUND_ROBIN_EN
      last_q           <= last_d;
`endif
    end
  end

  always_comb begin
    state_d          = state_q;
    win_d            = win_q;
    tmo_d            = tmo_q;
    cnt_d            = cnt_q;
    cap_d            = cap_q;
    mem_read_d       = mem_read_q;
    mem_write_d      = mem_write_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    d_rdata_d        = d_rdata_q;
    i_rdata_d        = i_rdata_q;
    d_ack_d          = 1'b0;
    i_ack_d          = 1'b0;
    d_err_d          = 1'b0;
    i_err_d          = 1'b0;
`ifdef CORE_BUS_ARBITER_ROUND_ROBIN_EN
    last_d           = last_q;
`endif

    unique case (state_q)
      IDLE: begin
        // The acked requester still holds req during its ack cycle; granting then
        // would replay the access it just completed.
        if (grant_valid && !d_ack_q && !i_ack_q) begin
          win_d = grant_id;
          cnt_d = '0;
          tmo_d = 1'b0;
          if (grant_id == REQ_DATA) begin
            mem_address_d    = d_addr;
            mem_write_data_d = d_wdata;
            mem_write_d      = d_we;
            mem_read_d       = ~d_we;
          end else begin
            mem_address_d    = i_addr;
            mem_write_data_d = '0;
            mem_write_d      = 1'b0;
            mem_read_d       = 1'b1;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_response) begin
          cap_d       = mem_read_data;
          tmo_d       = 1'b0;
          cnt_d       = '0;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = RESPOND;
        end else if (cnt_q == CNT_LAST) begin
          cap_d       = '0;
          tmo_d       = 1'b1;
          cnt_d       = '0;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = RESPOND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESPOND: begin
        if (win_q == REQ_DATA) begin
          d_ack_d   = 1'b1;
          d_err_d   = tmo_q;
          d_rdata_d = cap_q;
        end else begin
          i_ack_d   = 1'b1;
          i_err_d   = tmo_q;
          i_rdata_d = cap_q;
        end
`ifdef CORE_BUS_ARBITER_ROUND_ROBIN_EN
        last_d = win_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign d_rdata        = d_rdata_q;
  assign i_rdata        = i_rdata_q;
  assign d_ack          = d_ack_q;
  assign i_ack          = i_ack_q;
  assign d_err          = d_err_q;
  assign i_err          = i_err_q;

  // Stall must follow d_req within the same cycle, so it cannot be a flop.
  assign hold_o = d_req & ~d_ack_q & ~reset;

endmodule
